instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Upstream instruction sequencer for `cpu`.
- Holds the program in a synchronous instruction memory, loaded by a host word-by-word.
- On start, streams one 16-bit instruction per clock into `cpu.current_instruction`.
- Stops on the 16'hFFFF halt sentinel; sentinel is never forwarded, NOP is driven instead.

Parameters:
- INSTR_WIDTH, 16, instruction word width.
- DEPTH, 1024, instruction memory words.
- ADDR_WIDTH, $clog2(DEPTH), PC/address width.
- NOP_WORD, 16'h9000, idle filler (opcode 4'b1001, operands zero).
- HALT_WORD, 16'hFFFF, end-of-program sentinel.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  synchronous, active-high reset.
- load_valid_in  input  1  host write strobe.
- load_addr_in  input  ADDR_WIDTH  host write address.
- load_data_in  input  INSTR_WIDTH  host write data.
- load_ready_out  output  1  high when writes are accepted (IDLE or HALTED).
- start_in  input  1  begin execution at address 0.
- stop_in  input  1  abort execution.
- current_instruction  output  INSTR_WIDTH  registered instruction to `cpu`.
- pc_out  output  ADDR_WIDTH  address of the word on current_instruction.
- running_out  output  1  high in PRIME/RUN.
- halted_out  output  1  high in HALTED.
- overrun_out  output  1  sticky; program ran off the end of memory.
- instr_count_out  output  16  instructions issued since last start (saturating).

Behaviour:
- Reset (synchronous, active-high): state=IDLE; current_instruction=NOP_WORD; pc_out=0; running_out=0; halted_out=0; overrun_out=0; instr_count_out=0. Memory contents are not cleared.
- Reset mid-RUN: next cycle outputs reset values; no further words issued.
- Memory: 1-cycle synchronous read; write port used only when load_ready_out=1.
- IDLE / HALTED:
  - load_valid_in writes mem[load_addr_in].
  - start_in with load_valid_in=0 → PRIME: read address 0; clear instr_count_out, overrun_out, halted_out.
  - start_in together with load_valid_in: the load is performed and start is ignored.
- PRIME (1 cycle): → RUN. current_instruction stays NOP_WORD.
- RUN, each cycle, on the memory word W read for address A:
  - W != HALT_WORD: current_instruction<=W; pc_out<=A; instr_count_out+=1 (saturates at 16'hFFFF); read address A+1.
  - W == HALT_WORD: current_instruction<=NOP_WORD; → HALTED. pc_out holds the last issued address.
  - A == DEPTH-1 and W != HALT_WORD: W is issued; then → HALTED with overrun_out=1. No wrap to address 0.
  - stop_in (highest priority in RUN): current_instruction<=NOP_WORD; → IDLE; the word in flight is discarded.
- Latency: start_in sampled at edge N → first program word on current_instruction after edge N+2. Then one word per cycle, no bubbles.
- load_valid_in during PRIME/RUN: ignored (load_ready_out=0); memory is unchanged.
- halted_out stays high until the next start_in or reset.

Optional Feature:
- Macro: INSTRUCTION_FETCH_SINGLE_STEP_EN.
- Defined:
  - Adds input step_in (1 bit) and input step_mode_in (1 bit).
  - With step_mode_in=1, RUN issues exactly one new word per step_in pulse. Between pulses current_instruction=NOP_WORD and the PC does not advance.
  - Halt/overrun/stop rules are unchanged.
- Undefined: ports absent; free-running behaviour as above.

Decomposition:
- Package `fetch_pkg`:
  - State enum {IDLE, PRIME, RUN, HALTED}.
  - NOP_WORD, HALT_WORD constants.
  - Opcode field localparams shared with the `cpu` decoder.
- Sub-module `instruction_memory`: single-port synchronous RAM with write enable and 1-cycle read, instantiated once.

Test Plan:
- Run basic program:
  - Load {16'h0123, 16'h1456, 16'hFFFF} at 0..2, then pulse start_in.
  - Required: NOP for 2 cycles, then 16'h0123 (pc 0), 16'h1456 (pc 1), then NOP.
  - halted_out=1, instr_count_out=2.
- Stop mid-run:
  - 10-word program, stop_in asserted on the cycle the 4th word is output.
  - Required: next cycle NOP, running_out=0, state IDLE, instr_count_out=4.
- Overrun:
  - Fill all DEPTH words with 16'h2000 (no halt), then start.
  - Required: DEPTH words issued, then overrun_out=1, halted_out=1, NOP output.
- Load blocked during run:
  - During RUN, load_valid_in writes 16'hFFFF to an unread address.
  - Required: ignored; the original word is still issued. Start with a simultaneous load in IDLE: write lands, no PRIME.
- Synchronous reset mid-run:
  - Assert reset_in for 1 cycle during RUN.
  - Required: outputs equal reset values at the next edge; a restart reproduces the program from address 0.
- Single step (INSTRUCTION_FETCH_SINGLE_STEP_EN defined, step_mode_in=1):
  - 3 step_in pulses spaced 5 cycles apart.
  - Required: exactly 3 words issued, NOP in between, pc_out ends at 2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the cpu decoder:
// FSM states, idle/halt instruction words and the opcode field layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [15:0] NOP_WORD  = 16'h9000;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    // Opcode occupies the top nibble of every instruction word.
    localparam int         OPCODE_MSB = 15;
    localparam int         OPCODE_LSB = 12;
    localparam logic [3:0] OPC_NOP    = 4'b1001;
    localparam logic [3:0] OPC_HALT   = 4'b1111;

endpackage

// File: rtl/instruction_memory.sv
// Single-port synchronous RAM: registered read, write-enable, one access per clock.
module instruction_memory #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction sequencer feeding the cpu one word per clock from a host-loaded memory.
// Optional build macro INSTRUCTION_FETCH_SINGLE_STEP_EN adds step_in/step_mode_in.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     DEPTH       = 1024,
    parameter int                     ADDR_WIDTH  = $clog2(DEPTH),
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = fetch_pkg::NOP_WORD,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = fetch_pkg::HALT_WORD
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   load_valid_in,
    input  logic [ADDR_WIDTH-1:0]  load_addr_in,
    input  logic [INSTR_WIDTH-1:0] load_data_in,
    output logic                   load_ready_out,
    input  logic                   start_in,
    input  logic                   stop_in,
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
    input  logic                   step_in,
    input  logic                   step_mode_in,
`endif
    output logic [INSTR_WIDTH-1:0] current_instruction,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   running_out,
    output logic                   halted_out,
    output logic                   overrun_out,
    output logic [15:0]            instr_count_out
);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  fetch_addr;  // address of the word currently in mem_rdata
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic                   mem_we;
    logic                   advance;
    logic                   at_end;

    assign load_ready_out = (state == IDLE) || (state == HALTED);
    assign running_out    = (state == PRIME) || (state == RUN);
    assign halted_out     = (state == HALTED);
    assign mem_we         = load_valid_in && load_ready_out;
    assign at_end         = (fetch_addr == ADDR_WIDTH'(DEPTH - 1));

`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
    assign advance = !step_mode_in || step_in;
`else
    assign advance = 1'b1;
`endif

    // Without a step the same address is re-read so mem_rdata keeps the pending word.
    always_comb begin
        mem_addr = load_addr_in;
        case (state)
            PRIME:   mem_addr = '0;
            RUN:     mem_addr = advance ? fetch_addr + ADDR_WIDTH'(1) : fetch_addr;
            default: mem_addr = load_addr_in;
        endcase
    end

    instruction_memory #(
        .WIDTH      (INSTR_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clock_in),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (load_data_in),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state               <= IDLE;
            current_instruction <= NOP_WORD;
            pc_out              <= '0;
            overrun_out         <= 1'b0;
            instr_count_out     <= '0;
            fetch_addr          <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    current_instruction <= NOP_WORD;
                    if (start_in && !load_valid_in) begin
                        state           <= PRIME;
                        instr_count_out <= '0;
                        overrun_out     <= 1'b0;
                    end
                end
                PRIME: begin
                    current_instruction <= NOP_WORD;
                    fetch_addr          <= '0;
                    state               <= stop_in ? IDLE : RUN;
                end
                RUN: begin
                    if (stop_in) begin
                        current_instruction <= NOP_WORD;
                        state               <= IDLE;
                    end else if (!advance) begin
                        current_instruction <= NOP_WORD;
                    end else if (mem_rdata == HALT_WORD) begin
                        current_instruction <= NOP_WORD;
                        state               <= HALTED;
                    end else begin
                        current_instruction <= mem_rdata;
                        pc_out              <= fetch_addr;
                        fetch_addr          <= fetch_addr + ADDR_WIDTH'(1);
                        if (instr_count_out != 16'hFFFF) begin
                            instr_count_out <= instr_count_out + 16'd1;
                        end
                        // Last memory word issued: stop rather than wrap to address 0.
                        if (at_end) begin
                            overrun_out <= 1'b1;
                            state       <= HALTED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
